uart_tx_fifo: RTL and testbench

//   Parametrised UART transmitter with a TX FIFO and run-time frame format:
//   5..DATA_WIDTH data bits, parity none/even/odd, 1 or 2 stop bits, and a programmable bit period.

---
 rtl/uart_tx_fifo.sv | 245 ++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx_fifo                                                    |
// | Purpose  : UART transmitter fed by a TX FIFO, run-time frame format.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_cfg_i,
  input  logic [15:0]                   cfg_bit_period_i,
  input  logic [3:0]                    cfg_data_bits_i,
  input  logic [1:0]                    cfg_parity_i,
  input  logic                          cfg_stop2_i,
  input  logic                          tx_valid_i,
  input  logic [DATA_WIDTH-1:0]         tx_data_i,
  output logic                          tx_ready_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          uart_txd,
  output logic                          uart_tx_busy,
  output logic                          tx_done_o
);

  localparam int                c_AW                 = $clog2(FIFO_DEPTH);
  localparam int                c_CW                 = c_AW + 1;
  localparam logic [c_CW-1:0]   c_FULL               = c_CW'(FIFO_DEPTH);
  localparam logic [15:0]       c_DEFAULT_BIT_PERIOD = 16'(CLK_FREQ / BAUD_RATE - 1);
  localparam logic [3:0]        c_DW4                = 4'(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // FIFO
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]       r_wr_ptr;
  logic [c_AW-1:0]       r_rd_ptr;
  logic [c_CW-1:0]       r_count;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic [DATA_WIDTH-1:0] w_head;

  assign tx_ready_o   = (r_count != c_FULL);
  assign w_push       = tx_valid_i && tx_ready_o;
  assign w_empty      = (r_count == '0);
  assign w_head       = r_mem[r_rd_ptr];
  assign fifo_count_o = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_CW'(1);
      end
    end
  end

  // Configuration registers
  logic [15:0] r_cfg_period;
  logic [3:0]  r_cfg_bits;
  logic [1:0]  r_cfg_parity;
  logic        r_cfg_stop2;
  logic [3:0]  w_cfg_bits;

  always_comb begin
    w_cfg_bits = cfg_data_bits_i;
    if (cfg_data_bits_i < 4'd5) begin
      w_cfg_bits = 4'd5;
    end else if (cfg_data_bits_i > c_DW4) begin
      w_cfg_bits = c_DW4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_period <= c_DEFAULT_BIT_PERIOD;
      r_cfg_bits   <= c_DW4;
      r_cfg_parity <= 2'b00;
      r_cfg_stop2  <= 1'b0;
    end else if (wr_cfg_i) begin
      r_cfg_period <= cfg_bit_period_i;
      r_cfg_bits   <= w_cfg_bits;
      r_cfg_parity <= cfg_parity_i;
      r_cfg_stop2  <= cfg_stop2_i;
    end
  end

  // Parity of the head word over the currently configured data bits
  logic [DATA_WIDTH-1:0] w_mask;
  logic                  w_head_par;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      w_mask[i] = (i < int'(r_cfg_bits));
    end
  end

  assign w_head_par = ^(w_head & w_mask);

  // Transmit FSM and per-frame snapshot
  state_t                r_state;
  state_t                w_state_nxt;
  logic [15:0]           r_cnt;
  logic [15:0]           r_f_period;
  logic [3:0]            r_f_bits;
  logic                  r_f_par_en;
  logic                  r_f_stop2;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_bit;
  logic [3:0]            r_bit_idx;
  logic                  r_stop_idx;
  logic                  r_txd;
  logic                  r_done;
  logic                  w_bit_end;
  logic                  w_line;
  logic                  w_done;

  assign w_bit_end = (r_cnt == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    w_line      = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_line = 1'b0;
        if (w_bit_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_line = r_shift[0];
        if (w_bit_end && (r_bit_idx == r_f_bits - 4'd1)) begin
          w_state_nxt = r_f_par_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        w_line = r_par_bit;
        if (w_bit_end) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end && (r_stop_idx || !r_f_stop2)) begin
          w_done = 1'b1;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Config snapshot on pop keeps mid-frame writes out of the current frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_f_period <= '0;
      r_f_bits   <= c_DW4;
      r_f_par_en <= 1'b0;
      r_f_stop2  <= 1'b0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
    end else if (w_pop) begin
      r_cnt      <= r_cfg_period;
      r_f_period <= r_cfg_period;
      r_f_bits   <= r_cfg_bits;
      r_f_par_en <= (r_cfg_parity == 2'b01) || (r_cfg_parity == 2'b10);
      r_f_stop2  <= r_cfg_stop2;
      r_shift    <= w_head;
      r_par_bit  <= (r_cfg_parity == 2'b10) ? ~w_head_par : w_head_par;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
    end else if (r_state != S_IDLE) begin
      if (w_bit_end) begin
        r_cnt <= r_f_period;
        if (r_state == S_DATA) begin
          r_shift   <= r_shift >> 1;
          r_bit_idx <= r_bit_idx + 4'd1;
        end
        if (r_state == S_STOP) r_stop_idx <= 1'b1;
      end else begin
        r_cnt <= r_cnt - 16'd1;
      end
    end
  end

  // Line and done are registered, one clock behind the FSM state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_txd  <= 1'b1;
      r_done <= 1'b0;
    end else begin
      r_txd  <= w_line;
      r_done <= w_done;
    end
  end

  assign uart_txd     = r_txd;
  assign tx_done_o    = r_done;
  assign uart_tx_busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_tx_fifo                                                 |
// | Purpose  : Self-checking bench for uart_tx_fifo (vector table + scoreboard)|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_cfg = 1'b0;
  logic [15:0] cfg_period = '0;
  logic [3:0]  cfg_bits = '0;
  logic [1:0]  cfg_par = '0;
  logic        cfg_stop2 = 1'b0;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        tx_ready;
  logic [4:0]  fifo_count;
  logic        uart_txd;
  logic        uart_tx_busy;
  logic        tx_done;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_FREQ  (50000000),
    .BAUD_RATE (115200),
    .DATA_WIDTH(8),
    .FIFO_DEPTH(16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_cfg_i        (wr_cfg),
    .cfg_bit_period_i(cfg_period),
    .cfg_data_bits_i (cfg_bits),
    .cfg_parity_i    (cfg_par),
    .cfg_stop2_i     (cfg_stop2),
    .tx_valid_i      (tx_valid),
    .tx_data_i       (tx_data),
    .tx_ready_o      (tx_ready),
    .fifo_count_o    (fifo_count),
    .uart_txd        (uart_txd),
    .uart_tx_busy    (uart_tx_busy),
    .tx_done_o       (tx_done)
  );

  typedef struct {
    logic [8:0] data;
    int         nbits;
    bit         has_par;
    bit         pbit;
    int         period;
    int         total;
  } frame_t;

  typedef struct {
    bit         wr;
    int         period;
    int         bits_in;
    logic [1:0] par;
    bit         s2;
    logic [7:0] data;
    int         e_period;
    int         e_nbits;
    bit         e_haspar;
    bit         e_pbit;
    int         e_total;
  } vec_t;

  frame_t sb[$];
  int     n_cmp = 0;
  int     n_err = 0;
  int     frames_done = 0;
  int     stray_done = 0;
  int     cyc = 0;
  int     last_end = -1;
  bit     b2b_chk = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Line monitor: decodes every frame clock by clock against the scoreboard head
  frame_t mon_f;
  bit     mon_bad, mon_done_ok, mon_abort;
  int     mon_bad_k, mon_b, mon_start, mon_lim;
  logic   mon_got, mon_exp;

  always begin
    @(negedge clk);
    if (!rst && uart_txd === 1'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_frame_start", 32'(uart_txd), 32'd1);
        mon_lim = 0;
        while (uart_txd === 1'b0 && mon_lim < 5000) begin
          @(negedge clk);
          mon_lim++;
        end
      end else begin
        mon_f = sb.pop_front();
        mon_start = cyc;
        if (b2b_chk && last_end >= 0) check("back_to_back_start", mon_start, last_end + 1);
        mon_bad = 1'b0; mon_done_ok = 1'b1; mon_abort = 1'b0; mon_bad_k = 0; mon_got = 1'b0;
        for (int k = 0; k < mon_f.total; k++) begin
          if (k > 0) @(negedge clk);
          if (rst) begin
            mon_abort = 1'b1;
            break;
          end
          mon_b = k / (mon_f.period + 1);
          if (mon_b == 0) mon_exp = 1'b0;
          else if (mon_b <= mon_f.nbits) mon_exp = mon_f.data[mon_b-1];
          else if (mon_f.has_par && mon_b == mon_f.nbits + 1) mon_exp = mon_f.pbit;
          else mon_exp = 1'b1;
          if (uart_txd !== mon_exp && !mon_bad) begin
            mon_bad = 1'b1; mon_bad_k = k; mon_got = uart_txd;
          end
          if (tx_done !== (k == mon_f.total - 1)) mon_done_ok = 1'b0;
        end
        if (!mon_abort) begin
          n_cmp++;
          if (mon_bad) begin
            n_err++;
            $display("FAIL frame_bits data=%0h: clock %0d of frame got txd=%0b, required %0b",
                     mon_f.data, mon_bad_k, mon_got, !mon_got);
          end
          check("frame_done_pulse_position", 32'(mon_done_ok), 32'd1);
          last_end = cyc;
          frames_done++;
        end
      end
    end else if (tx_done === 1'b1) begin
      stray_done++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input int p, input int b, input logic [1:0] par, input bit s2);
    cfg_period = 16'(p); cfg_bits = 4'(b); cfg_par = par; cfg_stop2 = s2;
    wr_cfg = 1'b1;
    step();
    wr_cfg = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input frame_t f);
    tx_valid = 1'b1; tx_data = d;
    sb.push_back(f);
    step();
    tx_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int i = 0;
    while (frames_done < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, frames_done, target);
  endtask

  function automatic frame_t mk(input logic [7:0] d, input int nb, input bit hp, input bit pb,
                                input int per, input int tot);
    frame_t f;
    f.data = {1'b0, d}; f.nbits = nb; f.has_par = hp; f.pbit = pb; f.period = per; f.total = tot;
    return f;
  endfunction

  vec_t vt[9];
  int   accepted;
  int   fd0;

  initial begin
    //      wr  per bits par    s2 data   e_per nb hp pb total
    vt[0] = '{0,   0,  0, 2'b00, 0, 8'h5A, 433, 8, 0, 0, 4340};
    vt[1] = '{1,   3,  8, 2'b00, 0, 8'hA5,   3, 8, 0, 0,   40};
    vt[2] = '{1,   3,  7, 2'b01, 0, 8'h53,   3, 7, 1, 0,   40};
    vt[3] = '{1,   3,  7, 2'b10, 0, 8'h53,   3, 7, 1, 1,   40};
    vt[4] = '{1,   3,  7, 2'b01, 1, 8'h53,   3, 7, 1, 0,   44};
    vt[5] = '{1,   1,  3, 2'b00, 0, 8'hE6,   1, 5, 0, 0,   14};
    vt[6] = '{1,   0, 12, 2'b01, 0, 8'h81,   0, 8, 1, 0,   11};
    vt[7] = '{1,   2,  9, 2'b11, 1, 8'h3C,   2, 8, 0, 0,   33};
    vt[8] = '{1,   0,  5, 2'b10, 0, 8'h17,   0, 5, 1, 1,    8};

    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("reset_txd", 32'(uart_txd), 32'd1);
    check("reset_busy", 32'(uart_tx_busy), 32'd0);
    check("reset_done", 32'(tx_done), 32'd0);
    check("reset_count", 32'(fifo_count), 32'd0);
    check("reset_ready", 32'(tx_ready), 32'd1);

    for (int i = 0; i < 9; i++) begin
      step();
      if (vt[i].wr) write_cfg(vt[i].period, vt[i].bits_in, vt[i].par, vt[i].s2);
      fd0 = frames_done;
      push(vt[i].data, mk(vt[i].data, vt[i].e_nbits, vt[i].e_haspar, vt[i].e_pbit,
                          vt[i].e_period, vt[i].e_total));
      if (i == 1) begin
        @(negedge clk);
        check("lat_t_count", 32'(fifo_count), 32'd1);
        check("lat_t_busy", 32'(uart_tx_busy), 32'd0);
        check("lat_t_txd", 32'(uart_txd), 32'd1);
        @(negedge clk);
        check("lat_t1_count", 32'(fifo_count), 32'd0);
        check("lat_t1_busy", 32'(uart_tx_busy), 32'd1);
        check("lat_t1_txd", 32'(uart_txd), 32'd1);
        @(negedge clk);
        check("lat_t2_txd", 32'(uart_txd), 32'd0);
      end
      wait_frames(fd0 + 1, vt[i].e_total + 20, "vector_frame_complete");
      @(negedge clk);
      check("vector_idle_busy", 32'(uart_tx_busy), 32'd0);
      check("vector_idle_txd", 32'(uart_txd), 32'd1);
    end

    // FIFO fill while the line is stalled: 17 accepted, sent back to back
    step();
    write_cfg(200, 8, 2'b00, 1'b0);
    b2b_chk = 1'b1; last_end = -1;
    fd0 = frames_done;
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      tx_valid = 1'b1; tx_data = 8'(i);
      if (tx_ready === 1'b1) begin
        accepted++;
        sb.push_back(mk(8'(i), 8, 1'b0, 1'b0, 200, 2010));
      end
      step();
      if (i == 1) check("push_pop_same_edge_count", 32'(fifo_count), 32'd1);
    end
    tx_valid = 1'b0;
    check("fill_accepted", accepted, 32'd17);
    @(negedge clk);
    check("fill_count", 32'(fifo_count), 32'd16);
    check("fill_ready_low", 32'(tx_ready), 32'd0);
    wait_frames(fd0 + 17, 17 * 2010 + 100, "fill_frames_complete");
    b2b_chk = 1'b0;

    // Mid-frame config change applies from the next frame
    step();
    write_cfg(3, 8, 2'b00, 1'b0);
    b2b_chk = 1'b1; last_end = -1;
    fd0 = frames_done;
    push(8'hC3, mk(8'hC3, 8, 1'b0, 1'b0, 3, 40));
    push(8'h96, mk(8'h96, 8, 1'b0, 1'b0, 7, 80));
    repeat (10) step();
    write_cfg(7, 8, 2'b00, 1'b0);
    wait_frames(fd0 + 2, 200, "cfg_change_frames_complete");
    b2b_chk = 1'b0;

    // Reset mid-DATA with words still queued
    step();
    write_cfg(3, 8, 2'b00, 1'b0);
    fd0 = frames_done;
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i), mk(8'(8'h10 + i), 8, 1'b0, 1'b0, 3, 40));
    repeat (10) step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check("midreset_txd", 32'(uart_txd), 32'd1);
    check("midreset_busy", 32'(uart_tx_busy), 32'd0);
    check("midreset_count", 32'(fifo_count), 32'd0);
    step();
    rst = 1'b0;
    sb.delete();
    repeat (100) step();
    check("midreset_no_frame", frames_done, fd0);
    check("midreset_idle_busy", 32'(uart_tx_busy), 32'd0);
    check("stray_done_pulses", stray_done, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
